// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage scalar/vector pipeline: load-use bubbles, branch flushes, multi-cycle VALU hold.
// Optional: define STALL_CNT_EN to add the saturating stall_cnt_o cycle counter.
module pipe_hazard_ctrl #(
    parameter int VALU_LAT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_memread_i,
    input  logic        ex_valu_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_write_o,
    output logic        idex_bubble_o,
    output logic        exmem_bubble_o,
    output logic        valu_busy_o,
    output logic        valu_done_o
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    // state | meaning
    // IDLE  | normal flow; detects branch flush, vector start, load-use
    // VBUSY | vector op held in EX; cnt = stall cycles left before done cycle
    typedef enum logic {
        IDLE,
        VBUSY
    } state_t;

    localparam bit             MULTI     = (VALU_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_START = MULTI ? CNT_W'(VALU_LAT - 2) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             start_op;

    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    assign start_op = (state == IDLE) && !branch_taken_i && ex_valu_i && MULTI;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_op) begin
                        state <= VBUSY;
                        cnt   <= CNT_START;
                    end
                end
                VBUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded from state/cnt/inputs and forced low while reset is held.
    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        valu_busy_o    = 1'b0;
        valu_done_o    = 1'b0;
        if (!rst_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            idex_write_o = 1'b1;
            if (state == VBUSY) begin
                valu_busy_o = 1'b1;
                if (cnt == '0) begin
                    valu_done_o = 1'b1;
                end else begin
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    idex_write_o   = 1'b0;
                    exmem_bubble_o = 1'b1;
                end
            end else if (branch_taken_i) begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (ex_valu_i) begin
                if (MULTI) begin
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    idex_write_o   = 1'b0;
                    exmem_bubble_o = 1'b1;
                end else begin
                    valu_done_o = 1'b1;
                end
            end else if (load_use) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (!pc_write_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
